// File: rtl/hamming_decode_ctrl.sv
// -----------------------------------------------------------------------------
// hamming_decode_ctrl
// Shares one Hamming(7,4) syndrome-decode/correct datapath between two
// requesters. Requesters are granted round-robin, one codeword is in flight at
// a time, and the decoded nibble is returned on a valid/ready output tagged
// with the requester that sent it. A saturating counter tracks corrected words.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   req0_valid/ready/code    requester 0 codeword handshake (7-bit code)
//   req1_valid/ready/code    requester 1 codeword handshake (7-bit code)
//   out_valid/ready          decoded result handshake
//   out_data                 decoded nibble {c[6],c[5],c[4],c[2]}
//   out_src                  0 = requester 0, 1 = requester 1
//   out_corr                 1 = a single-bit error was corrected
//   clr_cnt                  synchronous clear of the counters (wins over +1)
//   cnt_corr                 saturating corrected-word count
//   cnt_drop                 saturating dropped-word count (HAM_STRICT_EN only)
//
// Build option
//   HAM_STRICT_EN  when defined, words with a nonzero syndrome are dropped
//                  instead of corrected: they are counted in cnt_drop and never
//                  reach the output; cnt_corr and out_corr stay 0.
// -----------------------------------------------------------------------------
module hamming_decode_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [6:0]       req0_code,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [6:0]       req1_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_data,
   output logic             out_src,
   output logic             out_corr,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt_corr
`ifdef HAM_STRICT_EN
   ,
   output logic [CNT_W-1:0] cnt_drop
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYND = 2'd1,
      ST_CORR = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Syndrome {s4,s2,s1}; the value names the 1-based position of a single error.
   function automatic logic [2:0] ham_syndrome(input logic [6:0] c);
      ham_syndrome = {c[3] ^ c[4] ^ c[5] ^ c[6],
                      c[1] ^ c[2] ^ c[5] ^ c[6],
                      c[0] ^ c[2] ^ c[4] ^ c[6]};
   endfunction

   // Flip the bit the syndrome points at; a zero syndrome leaves the word alone.
   function automatic logic [6:0] ham_correct(input logic [6:0] c, input logic [2:0] s);
      logic [6:0] flip;
      if (s != 3'd0) begin
         flip = 7'd1 << (s - 3'd1);
      end else begin
         flip = 7'd0;
      end
      ham_correct = c ^ flip;
   endfunction

   function automatic logic [3:0] ham_data(input logic [6:0] c);
      ham_data = {c[6], c[5], c[4], c[2]};
   endfunction

   state_t           state_q, state_d;
   logic             last_q, last_d;          // last granted requester
   logic [6:0]       code_q, code_d;
   logic             src_q, src_d;
   logic [2:0]       synd_q, synd_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       out_data_q, out_data_d;
   logic             out_src_q, out_src_d;
   logic             out_corr_q, out_corr_d;
   logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
   logic             grant_any_s;
   logic             grant_sel_s;
   logic             incr_corr_s;
`ifdef HAM_STRICT_EN
   logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;
   logic             incr_drop_s;
`endif

   // Round-robin arbitration; ready is only ever offered in IDLE.
   always_comb begin
      grant_any_s = 1'b0;
      grant_sel_s = 1'b0;
      if (state_q == ST_IDLE) begin
         if (req0_valid && req1_valid) begin
            grant_any_s = 1'b1;
            grant_sel_s = ~last_q;
         end else if (req0_valid) begin
            grant_any_s = 1'b1;
            grant_sel_s = 1'b0;
         end else if (req1_valid) begin
            grant_any_s = 1'b1;
            grant_sel_s = 1'b1;
         end else begin
            grant_any_s = 1'b0;
            grant_sel_s = 1'b0;
         end
      end else begin
         grant_any_s = 1'b0;
         grant_sel_s = 1'b0;
      end
      req0_ready = grant_any_s & ~grant_sel_s;
      req1_ready = grant_any_s &  grant_sel_s;
   end

   // Next-state and datapath-register logic.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      code_d      = code_q;
      src_d       = src_q;
      synd_d      = synd_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_corr_d  = out_corr_q;
      incr_corr_s = 1'b0;
`ifdef HAM_STRICT_EN
      incr_drop_s = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_any_s) begin
               code_d  = grant_sel_s ? req1_code : req0_code;
               src_d   = grant_sel_s;
               last_d  = grant_sel_s;
               state_d = ST_SYND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SYND: begin
            synd_d  = ham_syndrome(code_q);
            state_d = ST_CORR;
         end
         ST_CORR: begin
`ifdef HAM_STRICT_EN
            if (synd_q != 3'd0) begin
               incr_drop_s = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               out_data_d = ham_data(code_q);
               out_src_d  = src_q;
               out_corr_d = 1'b0;
               state_d    = ST_OUT;
            end
`else
            out_data_d  = ham_data(ham_correct(code_q, synd_q));
            out_src_d   = src_q;
            out_corr_d  = (synd_q != 3'd0);
            incr_corr_s = (synd_q != 3'd0);
            state_d     = ST_OUT;
`endif
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      out_valid_d = (state_d == ST_OUT);
   end

   // Saturating corrected-word counter; clear beats increment.
   always_comb begin
      cnt_corr_d = cnt_corr_q;
      if (clr_cnt) begin
         cnt_corr_d = CNT_ZERO;
      end else if (incr_corr_s && (cnt_corr_q != CNT_MAX)) begin
         cnt_corr_d = cnt_corr_q + CNT_ONE;
      end else begin
         cnt_corr_d = cnt_corr_q;
      end
   end

`ifdef HAM_STRICT_EN
   // Saturating dropped-word counter; clear beats increment.
   always_comb begin
      cnt_drop_d = cnt_drop_q;
      if (clr_cnt) begin
         cnt_drop_d = CNT_ZERO;
      end else if (incr_drop_s && (cnt_drop_q != CNT_MAX)) begin
         cnt_drop_d = cnt_drop_q + CNT_ONE;
      end else begin
         cnt_drop_d = cnt_drop_q;
      end
   end

   // Dropped-word counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_drop_q <= CNT_ZERO;
      end else begin
         cnt_drop_q <= cnt_drop_d;
      end
   end

   assign cnt_drop = cnt_drop_q;
`endif

   // State, datapath and output registers; reset discards any in-flight word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         code_q      <= 7'd0;
         src_q       <= 1'b0;
         synd_q      <= 3'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 4'd0;
         out_src_q   <= 1'b0;
         out_corr_q  <= 1'b0;
         cnt_corr_q  <= CNT_ZERO;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         code_q      <= code_d;
         src_q       <= src_d;
         synd_q      <= synd_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_corr_q  <= out_corr_d;
         cnt_corr_q  <= cnt_corr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_corr  = out_corr_q;
   assign cnt_corr  = cnt_corr_q;

endmodule
